// File: rtl/cb_stream_reader.sv
// cb_stream_reader
//   Read-side controller for circular_buffer. It drains the buffer read port
//   and presents the words as a valid/ready stream. The stream is framed into
//   PKT_LEN-word packets, and m_last marks the final beat of each packet.
//
// Optional feature:
//   CB_READER_PKT_GATE_EN - when defined, a new packet's first read waits
//   until buf_count >= PKT_LEN. When undefined, buf_count is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   enable     permits new buffer reads
//   buf_empty  buffer empty flag
//   buf_count  buffer occupancy (ADDR_W+1 bits)
//   buf_data   buffer data_out, valid one cycle after a sampled read
//   buf_rd_en  buffer read_en
//   m_data     stream data (head of the output queue)
//   m_valid    stream valid (output queue non-empty)
//   m_ready    consumer ready
//   m_last     final beat of a packet
//   pkt_cnt    completed packets, wraps at 16 bits
//
// FSM states:
//   state | meaning
//   IDLE  | no packet being fetched; fetch_cnt = 0
//   FETCH | mid-packet; fetch_cnt = reads issued so far for this packet
module cb_stream_reader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              buf_empty,
  input  logic [ADDR_W:0]   buf_count,
  input  logic [DATA_W-1:0] buf_data,
  output logic              buf_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       pkt_cnt
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     fetch_cnt, fetch_cnt_nxt;
  logic [CW-1:0]     beat_cnt;
  logic              infl;
  logic              infl_last;
  logic [1:0]        occ;
  logic [DATA_W-1:0] q_data [2];
  logic [1:0]        q_last;
  logic              pop;
  logic              fsm_ok;
  logic              credit_ok;
  logic              issue_last;
  logic [2:0]        load;

  assign m_valid = (occ != 2'd0);
  assign m_data  = q_data[0];
  // The stale tag left behind after a drain must not leak out.
  assign m_last  = m_valid & q_last[0];
  assign pop     = m_valid & m_ready;

  // occ+infl never exceeds 2. At 2, a slot frees only when a pop happens
  // in the same cycle.
  assign load      = {1'b0, occ} + {2'b00, infl};
  assign credit_ok = (load < 3'd2) || ((load == 3'd2) && pop);

`ifdef CB_READER_PKT_GATE_EN
  assign fsm_ok = (state == FETCH) || (buf_count >= CW'(PKT_LEN));
`else
  logic unused_count;
  assign unused_count = ^buf_count;
  assign fsm_ok       = 1'b1;
`endif

  always_comb begin
    state_nxt     = state;
    fetch_cnt_nxt = fetch_cnt;
    issue_last    = (fetch_cnt == LAST_IDX);
    // rst gates the read so that it drops as soon as reset asserts.
    buf_rd_en     = rst & enable & ~buf_empty & fsm_ok & credit_ok;
    if (buf_rd_en) begin
      if (issue_last) begin
        state_nxt     = IDLE;
        fetch_cnt_nxt = '0;
      end else begin
        state_nxt     = FETCH;
        fetch_cnt_nxt = fetch_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_cnt <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_cnt <= fetch_cnt_nxt;
      infl      <= buf_rd_en;
      if (buf_rd_en) infl_last <= issue_last;
    end
  end

  // A push comes from the read issued on the previous cycle.
  // While a read is in flight, occ is at most 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= 2'd0;
      q_data[0] <= '0;
      q_data[1] <= '0;
      q_last    <= 2'b00;
    end else begin
      case ({infl, pop})
        2'b10: begin
          q_data[occ[0]] <= buf_data;
          q_last[occ[0]] <= infl_last;
          occ            <= occ + 2'd1;
        end
        2'b01: begin
          q_data[0] <= q_data[1];
          q_last[0] <= q_last[1];
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            q_data[0] <= buf_data;
            q_last[0] <= infl_last;
          end else begin
            q_data[0] <= q_data[1];
            q_last[0] <= q_last[1];
            q_data[1] <= buf_data;
            q_last[1] <= infl_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      pkt_cnt  <= 16'd0;
    end else if (pop) begin
      if (m_last) begin
        beat_cnt <= '0;
        pkt_cnt  <= pkt_cnt + 16'd1;
      end else begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cb_stream_reader.sv
module tb_cb_stream_reader;

  localparam int PKT_LEN = 4;
`ifdef CB_READER_PKT_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       buf_empty = 1'b1;
  logic [3:0] buf_count = 4'd0;
  logic [7:0] buf_data = 8'd0;
  logic       buf_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;
  logic [15:0] pkt_cnt;

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] mem [$];

  always #5 clk = ~clk;

  cb_stream_reader #(.DATA_W(8), .ADDR_W(3), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rst(rst), .enable(enable), .buf_empty(buf_empty),
    .buf_count(buf_count), .buf_data(buf_data), .buf_rd_en(buf_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .pkt_cnt(pkt_cnt)
  );

  // Depth-8 buffer with one-cycle read latency.
  always @(posedge clk) begin
    if (buf_rd_en && mem.size() != 0) buf_data <= mem.pop_front();
    if (wr_en && mem.size() < 8) mem.push_back(wr_data);
    buf_count <= 4'(mem.size());
    buf_empty <= (mem.size() == 0);
  end

  // Reference: words leave in write order. Beat k after reset carries
  // last = (k % PKT_LEN == PKT_LEN-1). At most two words sit between
  // the buffer and the consumer.
  logic [7:0] exp_q [$];
  int n_tests = 0, n_fail = 0;
  int exp_pkt = 0, beat_idx = 0, outstanding = 0, cycle_no = 0;
  int reads_win = 0, beats_win = 0;
  int first_rd = -1, first_beat = -1, last_beat = -1;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic prev_last = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle_no);
    end
  endtask

  task automatic tick();
    logic pop_now;
    logic [7:0] exp_d;
    logic exp_l;
    #1;
    pop_now = m_valid & m_ready;
    check("no_underflow", int'(buf_rd_en & buf_empty), 0);
    check("pkt_cnt", int'(pkt_cnt), exp_pkt);
    if (buf_rd_en) check("credit", int'(outstanding + 1 - int'(pop_now) <= 2), 1);
    if (prev_stall) begin
      check("stall_valid", int'(m_valid), 1);
      check("stall_data", int'(m_data), int'(prev_data));
      check("stall_last", int'(m_last), int'(prev_last));
    end
    if (pop_now) begin
      if (exp_q.size() == 0) check("extra_beat", int'(m_data), -1);
      else begin
        exp_d = exp_q.pop_front();
        exp_l = ((beat_idx % PKT_LEN) == PKT_LEN - 1);
        check("data", int'(m_data), int'(exp_d));
        check("last", int'(m_last), int'(exp_l));
        if (exp_l) exp_pkt = (exp_pkt + 1) % 65536;
        beat_idx++;
        beats_win++;
        if (first_beat < 0) first_beat = cycle_no;
        last_beat = cycle_no;
      end
    end
    if (buf_rd_en) begin
      reads_win++;
      if (first_rd < 0) first_rd = cycle_no;
    end
    outstanding = outstanding + int'(buf_rd_en) - int'(pop_now);
    prev_stall = m_valid & ~m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic write_word(input logic [7:0] d);
    int n = 0;
    while (buf_count == 4'd8 && n < 50) begin
      tick();
      n++;
    end
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || outstanding != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic clear_win();
    reads_win = 0; beats_win = 0;
    first_rd = -1; first_beat = -1; last_beat = -1;
  endtask

  initial begin
    int n, rem, pad, left;
    // Reset state
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(m_valid), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_pkt", int'(pkt_cnt), 0);
    check("rst_rd_en", int'(buf_rd_en), 0);
    rst = 1'b1;

    // Fill then stream at full rate
    enable = 1'b0;
    for (int i = 1; i <= 8; i++) write_word(8'(i));
    clear_win();
    enable = 1'b1;
    drain(60);
    check("t1_latency", first_beat - first_rd, 2);
    check("t1_back_to_back", last_beat - first_beat, 7);
    check("t1_pkt", int'(pkt_cnt), 2);

    // Backpressure with m_ready toggling
    enable = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'($urandom_range(0, 255)));
    enable = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && n < 80) begin
      m_ready = cycle_no[0];
      tick();
      n++;
    end
    if (exp_q.size() != 0 || outstanding != 0) check("t2_timeout", exp_q.size(), 0);
    check("t2_pkt", int'(pkt_cnt), 4);

    // Starvation mid-packet
    m_ready = 1'b1;
    clear_win();
    write_word(8'd1);
    write_word(8'd2);
    repeat (10) tick();
    check("t3_gap_valid", int'(m_valid), 0);
    check("t3_pre_beats", beats_win, GATE ? 0 : 2);
    write_word(8'd3);
    write_word(8'd4);
    drain(40);
    check("t3_pkt", int'(pkt_cnt), 5);

    // Packet gate
    clear_win();
    write_word(8'd1);
    write_word(8'd2);
    write_word(8'd3);
    repeat (5) tick();
    check("t4_reads_pre", reads_win, GATE ? 0 : 3);
    write_word(8'd4);
    drain(40);
    check("t4_reads_total", reads_win, 4);
    check("t4_pkt", int'(pkt_cnt), 6);

    // Enable drop after two reads
    enable = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'(8'h40 + i));
    clear_win();
    enable = 1'b1;
    n = 0;
    while (reads_win < 2 && n < 20) begin
      tick();
      n++;
    end
    enable = 1'b0;
    repeat (6) tick();
    check("t5_reads_held", reads_win, 2);
    check("t5_beats_out", beats_win, 2);
    enable = 1'b1;
    drain(40);
    check("t5_reads_total", reads_win, 4);
    check("t5_pkt", int'(pkt_cnt), 7);

    // Async reset mid-stream
    enable = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'(8'h80 + i));
    enable = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check("t6_valid_seen", int'(m_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", int'(m_valid), 0);
    check("t6_rst_last", int'(m_last), 0);
    check("t6_rst_rd_en", int'(buf_rd_en), 0);
    check("t6_rst_pkt", int'(pkt_cnt), 0);
    for (int i = 0; i < outstanding; i++) void'(exp_q.pop_front());
    outstanding = 0; beat_idx = 0; exp_pkt = 0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ready = 1'b1;
    rem = exp_q.size();
    pad = (PKT_LEN - rem % PKT_LEN) % PKT_LEN;
    for (int i = 0; i < pad; i++) write_word(8'(8'hC0 + i));
    rem = rem + pad;
    drain(80);
    check("t6_pkt", int'(pkt_cnt), rem / PKT_LEN);

    // Randomized soak
    left = 40;
    n = 0;
    while (left > 0 && n < 600) begin
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      if (buf_count < 4'd8 && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_data = 8'($urandom_range(0, 255));
        exp_q.push_back(wr_data);
        left--;
      end
      tick();
      wr_en = 1'b0;
      n++;
    end
    check("t7_all_written", left, 0);
    enable = 1'b1;
    m_ready = 1'b1;
    drain(200);
    check("t7_final_pkt", int'(pkt_cnt), exp_pkt);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cb_stream_reader.md
Name: cb_stream_reader

Overview:
- Read-side controller for circular_buffer.
- Drains words from the buffer's read port (write_en/read_en/data_in/data_out/full/empty/count) and presents them as a valid/ready stream, framed into fixed-length packets with a last marker.
- Sits between circular_buffer and any downstream consumer. Owns all read_en generation so the buffer never underflows and the consumer may stall freely.

Parameters:
- DATA_W, 8, data word width; matches the buffer.
- ADDR_W, 3, buffer address width; buf_count is ADDR_W+1 bits (depth 2**ADDR_W = 8).
- PKT_LEN, 4, words per packet; range 1..2**ADDR_W.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- enable  input  1  permits new buffer reads when 1.
- buf_empty  input  1  buffer empty flag.
- buf_count  input  ADDR_W+1  buffer occupancy.
- buf_data  input  DATA_W  buffer data_out.
- buf_rd_en  output  1  drives the buffer read_en.
- m_data  output  DATA_W  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  consumer ready.
- m_last  output  1  high on the final beat of each packet.
- pkt_cnt  output  16  completed packets; wraps 0xFFFF->0.

Behaviour:
- Reset (rst=0, async):
  - Outputs: buf_rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_cnt=0.
  - Internal state: output queue emptied, in-flight flag cleared, beat_cnt=0, fetch_cnt=0, FSM=IDLE.
  - A read in flight at reset is discarded. The buffer keeps its own pointers.
- Buffer read latency is 1 cycle: buf_data is valid after the edge that samples buf_rd_en=1. The reader captures it into the queue on the following edge.
- Output queue: 2 entries, FIFO order. m_valid = queue non-empty. m_data/m_last come from the head entry.
- Beat transfer: m_valid & m_ready at a rising edge pops the head.
- Credit rule: with occ = queue entries and infl = read in flight (0/1), buf_rd_en=1 iff all of the following hold:
  - enable=1;
  - buf_empty=0;
  - FSM permits;
  - (occ+infl<2) or (occ+infl==2 and a pop occurs this cycle).
- buf_rd_en is combinational from registered state, buf_empty, buf_count, enable and m_ready.
- Queue overflow is impossible by construction; a simultaneous push and pop is legal.
- Throughput: with m_ready=1 and data available, 1 word/cycle sustained. First m_valid appears 2 edges after the first sampled buf_rd_en.
- FSM:
  - IDLE: fetch_cnt=0. Go to FETCH when a read issues (first word of a packet).
  - FETCH: each issued read increments fetch_cnt. When the PKT_LEN-th read issues, return to IDLE with fetch_cnt=0.
  - The next packet's fetch may overlap the draining of the previous packet.
- Framing:
  - beat_cnt counts popped beats 0..PKT_LEN-1.
  - m_last = (beat_cnt==PKT_LEN-1) for the head entry, stored with the entry at capture time (tag from fetch_cnt).
  - A pop with m_last=1 resets beat_cnt to 0 and increments pkt_cnt.
- enable deassert: no new reads. The in-flight word is still captured, queued words still drain, and FSM/fetch_cnt hold. Packet framing resumes on re-enable.
- buf_empty=1 with FETCH mid-packet: reads stall and the packet completes when data returns. m_valid may drop between beats.
- m_data/m_last are stable while m_valid=1 and m_ready=0.
- The reader never asserts buf_rd_en while buf_empty=1 (no underflow reads).

Optional Feature:
- Macro: CB_READER_PKT_GATE_EN.
- Defined: in IDLE, a read may start only if buf_count >= PKT_LEN. Once in FETCH, reads follow the normal rule. Buffer-side fetching of each packet is therefore contiguous whenever the consumer keeps up.
- Undefined: IDLE starts fetching whenever buf_empty=0. buf_count is unused.

Test Plan:
- Reset then fill: buffer loaded with 1..8, enable=1, m_ready=1 -> m_data 1,2,...,8 on consecutive cycles; m_last on 4 and 8; pkt_cnt=2; buf_rd_en never high while buf_empty=1.
- Backpressure: 8 words queued, m_ready toggles 1/0 every cycle -> no word lost or duplicated; buf_rd_en held low while occ+infl=2 and no pop; m_data stable during stalls.
- Starvation mid-packet: write 1,2 only, then after 10 cycles write 3,4 -> beats 1,2, gap with m_valid=0, then 3,4 with m_last on 4; pkt_cnt=1.
- Packet gate (macro defined): write 1,2,3 -> buf_rd_en stays 0; write 4 -> four reads issue; data 1..4 with m_last on 4. Macro undefined: reads start at word 1.
- Enable drop: disable after 2 reads issued -> both words delivered, no further reads; re-enable -> packet completes with correct m_last.
- Async reset mid-stream: rst=0 between edges while m_valid=1 -> m_valid, m_last and buf_rd_en fall immediately; pkt_cnt=0; after release, streaming restarts at beat_cnt=0.
